// File: rtl/uart_trx.sv
// Full-duplex UART: TX serialises tx_data on act, RX synchronises rx_line and reports each frame with a valid pulse.
// Both directions are fixed-rate with no backpressure: act is ignored while busy_tx, and valid is a pulse the consumer must take.
module uart_trx #(
   parameter int DIV       = 868,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 act,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_line,
   output logic                 busy_tx,
   input  logic                 rx_line,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 valid,
   output logic                 err,
   output logic                 perr,
   output logic                 busy_rx
);
   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
   localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
   localparam logic ODD     = (PARITY == 1);
   localparam logic HAS_PAR = (PARITY != 0);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   state_t               tx_st;
   logic [CW-1:0]        tx_cnt;
   logic [3:0]           tx_bit;
   logic [DATA_BITS-1:0] tx_sh;
   logic                 tx_par;
   logic                 tx_tick;

   assign tx_tick = (tx_cnt == DIV_M1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_st   <= S_IDLE;
         tx_cnt  <= '0;
         tx_bit  <= '0;
         tx_sh   <= '0;
         tx_par  <= 1'b0;
         tx_line <= 1'b1;
         busy_tx <= 1'b0;
      end else begin
         tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
         case (tx_st)
            S_IDLE: begin
               tx_cnt <= '0;
               if (act) begin
                  tx_sh   <= tx_data;
                  tx_par  <= (^tx_data) ^ ODD;
                  tx_st   <= S_START;
                  busy_tx <= 1'b1;
                  tx_line <= 1'b0;
               end
            end
            S_START: if (tx_tick) begin
               tx_line <= tx_sh[0];
               tx_sh   <= tx_sh >> 1;
               tx_bit  <= '0;
               tx_st   <= S_DATA;
            end
            S_DATA: if (tx_tick) begin
               if (tx_bit == LAST_BIT) begin
                  tx_bit <= '0;
                  if (HAS_PAR) begin
                     tx_line <= tx_par;
                     tx_st   <= S_PAR;
                  end else begin
                     tx_line <= 1'b1;
                     tx_st   <= S_STOP;
                  end
               end else begin
                  tx_line <= tx_sh[0];
                  tx_sh   <= tx_sh >> 1;
                  tx_bit  <= tx_bit + 1'b1;
               end
            end
            S_PAR: if (tx_tick) begin
               tx_line <= 1'b1;
               tx_bit  <= '0;
               tx_st   <= S_STOP;
            end
            S_STOP: if (tx_tick) begin
               if (tx_bit == LAST_STOP) begin
                  busy_tx <= 1'b0;
                  tx_st   <= S_IDLE;
               end else begin
                  tx_bit <= tx_bit + 1'b1;
               end
            end
            default: tx_st <= S_IDLE;
         endcase
      end
   end

   logic                 s1;
   logic                 rs;
   logic                 armed;
   state_t               rx_st;
   logic [CW-1:0]        rx_cnt;
   logic [3:0]           rx_bit;
   logic [DATA_BITS-1:0] rx_sh;
   logic                 rx_pbad;

   // armed clears whenever a frame starts, so a line stuck low after a frame cannot retrigger
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1      <= 1'b1;
         rs      <= 1'b1;
         armed   <= 1'b0;
         rx_st   <= S_IDLE;
         rx_cnt  <= '0;
         rx_bit  <= '0;
         rx_sh   <= '0;
         rx_pbad <= 1'b0;
         rx_data <= '0;
         valid   <= 1'b0;
         err     <= 1'b0;
         perr    <= 1'b0;
         busy_rx <= 1'b0;
      end else begin
         s1    <= rx_line;
         rs    <= s1;
         valid <= 1'b0;
         if (rx_st != S_IDLE)
            rx_cnt <= rx_cnt - 1'b1;
         case (rx_st)
            S_IDLE: begin
               if (rs) begin
                  armed <= 1'b1;
               end else if (armed) begin
                  armed   <= 1'b0;
                  busy_rx <= 1'b1;
                  rx_cnt  <= HALF_M1;
                  rx_st   <= S_START;
               end
            end
            S_START: if (rx_cnt == '0) begin
               if (rs) begin
                  busy_rx <= 1'b0;
                  rx_st   <= S_IDLE;
               end else begin
                  rx_cnt  <= DIV_M1;
                  rx_bit  <= '0;
                  rx_pbad <= 1'b0;
                  rx_st   <= S_DATA;
               end
            end
            S_DATA: if (rx_cnt == '0) begin
               rx_sh  <= {rs, rx_sh[DATA_BITS-1:1]};
               rx_cnt <= DIV_M1;
               if (rx_bit == LAST_BIT)
                  rx_st <= HAS_PAR ? S_PAR : S_STOP;
               else
                  rx_bit <= rx_bit + 1'b1;
            end
            S_PAR: if (rx_cnt == '0) begin
               rx_pbad <= rs ^ (^rx_sh) ^ ODD;
               rx_cnt  <= DIV_M1;
               rx_st   <= S_STOP;
            end
            S_STOP: if (rx_cnt == '0) begin
               valid   <= 1'b1;
               rx_data <= rx_sh;
               err     <= ~rs;
               perr    <= rx_pbad;
               busy_rx <= 1'b0;
               rx_st   <= S_IDLE;
            end
            default: rx_st <= S_IDLE;
         endcase
      end
   end
endmodule
